// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and access-legality decode for the
// load/store initiator.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP,
    ST_ERR
  } lsu_state_t;

  // High when the access must be rejected without touching memory.
  function automatic logic access_fault(input logic       we,
                                        input logic [2:0] f3,
                                        input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (we) begin
      bad = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    end else begin
      bad = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    end
    if ((f3 == F3_H || f3 == F3_HU) && addr_lo[0]) begin
      bad = 1'b1;
    end
    if (f3 == F3_W && addr_lo != 2'b00) begin
      bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte/halfword lane handling: load extraction with extension, and store
// merge of a narrow value into the containing word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] load_word,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  function automatic logic [31:0] extract_lane(input logic [2:0]  f3,
                                               input logic [1:0]  a,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'h000000, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'h0000, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_lane(input logic [2:0]  f3,
                                             input logic [1:0]  a,
                                             input logic [31:0] old_w,
                                             input logic [31:0] d);
    logic [31:0] r;
    r = old_w;
    case (f3)
      F3_B:    r[{a, 3'b000} +: 8] = d[7:0];
      F3_H:    r[{a[1], 4'b0000} +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  assign load_data  = extract_lane(funct3, addr_lo, load_word);
  assign store_word = merge_lane(funct3, addr_lo, old_word, wdata);

endmodule

// File: rtl/lsu_mem_master.sv
// Single-outstanding RV32I load/store initiator driving a word-organised RAM;
// narrow stores are read-modify-write of the containing word.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          REQ,
  input  logic          WE,
  input  logic [2:0]    FUNCT3,
  input  logic [31:0]   ADDR,
  input  logic [31:0]   WDATA,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERROR,
  output logic [31:0]   RDATA,
  output logic          MEM_READ,
  output logic          MEM_WRITE,
  output logic [AW-1:0] MEM_ADDRESS,
  output logic [31:0]   MEM_WDATA,
  input  logic [31:0]   MEM_RDATA
);

  lsu_state_t state_q, state_d;

  logic          we_q;
  logic [2:0]    f3_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   word_q;
  logic [31:0]   rdata_q;
  logic [31:0]   load_data;
  logic [31:0]   merged_word;
  logic          accept;
  logic          unused_addr_hi;

  // Addresses wrap: bits above the RAM's byte range are dropped.
  assign unused_addr_hi = ^ADDR[31:AW+2];

  assign accept = (state_q == ST_IDLE) && REQ;

  lsu_align u_align (
    .funct3     (f3_q),
    .addr_lo    (addr_q[1:0]),
    .load_word  (MEM_RDATA),
    .old_word   (word_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (merged_word)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (REQ) begin
          if (access_fault(WE, FUNCT3, ADDR[1:0])) begin
            state_d = ST_ERR;
          end else if (!WE || FUNCT3 != F3_W) begin
            state_d = ST_RD;
          end else begin
            state_d = ST_WR;
          end
        end
      end
      ST_RD:   state_d = we_q ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch and the word captured during RD carry no reset; they are
  // only observed through state-qualified outputs.
  always_ff @(posedge CLK) begin
    if (accept) begin
      we_q    <= WE;
      f3_q    <= FUNCT3;
      addr_q  <= ADDR[AW+1:0];
      wdata_q <= WDATA;
    end
    if (state_q == ST_RD) begin
      word_q <= MEM_RDATA;
    end
  end

  // Load result is formed while leaving RD so it is already valid with DONE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rdata_q <= '0;
    end else if (state_q == ST_RD && !we_q) begin
      rdata_q <= load_data;
    end
  end

  assign RDATA = rdata_q;

  always_comb begin
    BUSY        = (state_q != ST_IDLE);
    DONE        = 1'b0;
    ERROR       = 1'b0;
    MEM_READ    = 1'b0;
    MEM_WRITE   = 1'b0;
    MEM_ADDRESS = '0;
    MEM_WDATA   = '0;
    case (state_q)
      ST_RD: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = addr_q[AW+1:2];
      end
      ST_WR: begin
        MEM_WRITE   = 1'b1;
        MEM_ADDRESS = addr_q[AW+1:2];
        MEM_WDATA   = (f3_q == F3_W) ? wdata_q : merged_word;
      end
      ST_RESP: begin
        DONE = 1'b1;
      end
      ST_ERR: begin
        DONE  = 1'b1;
        ERROR = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a behavioural word RAM.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  localparam int AW = 10;

  logic          CLK;
  logic          RESET;
  logic          REQ;
  logic          WE;
  logic [2:0]    FUNCT3;
  logic [31:0]   ADDR;
  logic [31:0]   WDATA;
  logic          BUSY;
  logic          DONE;
  logic          ERROR;
  logic [31:0]   RDATA;
  logic          MEM_READ;
  logic          MEM_WRITE;
  logic [AW-1:0] MEM_ADDRESS;
  logic [31:0]   MEM_WDATA;
  logic [31:0]   MEM_RDATA;

  logic [31:0]   ram [0:(1<<AW)-1];
  logic          tb_we;
  logic [AW-1:0] tb_waddr;
  logic [31:0]   tb_wdata;
  int            wr_cnt;
  int            rd_cnt;
  int            vec_cnt;
  int            err_cnt;

  lsu_mem_master #(.AW(AW)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .REQ         (REQ),
    .WE          (WE),
    .FUNCT3      (FUNCT3),
    .ADDR        (ADDR),
    .WDATA       (WDATA),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .ERROR       (ERROR),
    .RDATA       (RDATA),
    .MEM_READ    (MEM_READ),
    .MEM_WRITE   (MEM_WRITE),
    .MEM_ADDRESS (MEM_ADDRESS),
    .MEM_WDATA   (MEM_WDATA),
    .MEM_RDATA   (MEM_RDATA)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  assign MEM_RDATA = ram[MEM_ADDRESS];

  always @(posedge CLK) begin
    if (MEM_WRITE) begin
      ram[MEM_ADDRESS] <= MEM_WDATA;
      wr_cnt <= wr_cnt + 1;
    end else if (tb_we) begin
      ram[tb_waddr] <= tb_wdata;
    end
    if (MEM_READ) rd_cnt <= rd_cnt + 1;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    tick();
    tb_we = 1'b0;
  endtask

  // Presents a request in the current (IDLE) cycle N and returns in cycle N+1.
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    WE = we; FUNCT3 = f3; ADDR = a; WDATA = d; REQ = 1'b1;
    tick();
    REQ = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick(); tick();
    RESET = 1'b0;
    vec_cnt++; if ({BUSY, DONE, ERROR, MEM_READ, MEM_WRITE} !== 5'b0) begin err_cnt++; $display("FAIL reset_flags got %b exp 00000", {BUSY, DONE, ERROR, MEM_READ, MEM_WRITE}); end
    vec_cnt++; if (RDATA !== 32'h0) begin err_cnt++; $display("FAIL reset_rdata got %h exp 00000000", RDATA); end
    vec_cnt++; if (MEM_ADDRESS !== '0 || MEM_WDATA !== 32'h0) begin err_cnt++; $display("FAIL reset_mem got %h/%h exp 0/0", MEM_ADDRESS, MEM_WDATA); end
  endtask

  task automatic test_lw();
    issue(1'b0, F3_W, 32'h8, 32'h0);
    vec_cnt++; if (MEM_READ !== 1'b1 || MEM_WRITE !== 1'b0 || BUSY !== 1'b1 || DONE !== 1'b0) begin err_cnt++; $display("FAIL lw_rd strobes rd=%b wr=%b busy=%b done=%b exp 1 0 1 0", MEM_READ, MEM_WRITE, BUSY, DONE); end
    vec_cnt++; if (MEM_ADDRESS !== 10'd2) begin err_cnt++; $display("FAIL lw_addr got %0d exp 2", MEM_ADDRESS); end
    tick();
    vec_cnt++; if (DONE !== 1'b1 || ERROR !== 1'b0 || MEM_READ !== 1'b0) begin err_cnt++; $display("FAIL lw_done done=%b err=%b rd=%b exp 1 0 0", DONE, ERROR, MEM_READ); end
    vec_cnt++; if (RDATA !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL lw_rdata got %h exp deadbeef", RDATA); end
    tick();
    vec_cnt++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin err_cnt++; $display("FAIL lw_idle busy=%b done=%b exp 0 0", BUSY, DONE); end
  endtask

  task automatic test_narrow_loads();
    logic [2:0]  f3s  [4] = '{F3_B, F3_BU, F3_H, F3_HU};
    logic [31:0] adrs [4] = '{32'hB, 32'hB, 32'hA, 32'h8};
    logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
    preload(10'd2, 32'h80FF7F01);
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, f3s[i], adrs[i], 32'h0);
      tick();
      vec_cnt++; if (DONE !== 1'b1 || RDATA !== exps[i]) begin err_cnt++; $display("FAIL narrow_load[%0d] done=%b rdata=%h exp 1 %h", i, DONE, RDATA, exps[i]); end
      tick();
    end
  endtask

  task automatic test_sb_rmw();
    int w0;
    preload(10'd1, 32'h11223344);
    w0 = wr_cnt;
    issue(1'b1, F3_B, 32'h5, 32'h000000AA);
    vec_cnt++; if (MEM_READ !== 1'b1 || MEM_WRITE !== 1'b0 || MEM_ADDRESS !== 10'd1) begin err_cnt++; $display("FAIL sb_rd rd=%b wr=%b addr=%0d exp 1 0 1", MEM_READ, MEM_WRITE, MEM_ADDRESS); end
    tick();
    vec_cnt++; if (MEM_WRITE !== 1'b1 || MEM_READ !== 1'b0 || MEM_ADDRESS !== 10'd1) begin err_cnt++; $display("FAIL sb_wr wr=%b rd=%b addr=%0d exp 1 0 1", MEM_WRITE, MEM_READ, MEM_ADDRESS); end
    vec_cnt++; if (MEM_WDATA !== 32'h1122AA44) begin err_cnt++; $display("FAIL sb_wdata got %h exp 1122aa44", MEM_WDATA); end
    tick();
    vec_cnt++; if (DONE !== 1'b1 || ERROR !== 1'b0 || RDATA !== 32'h00007F01) begin err_cnt++; $display("FAIL sb_done done=%b err=%b rdata=%h exp 1 0 00007f01", DONE, ERROR, RDATA); end
    tick();
    vec_cnt++; if (wr_cnt - w0 !== 1 || ram[1] !== 32'h1122AA44) begin err_cnt++; $display("FAIL sb_ram writes=%0d ram=%h exp 1 1122aa44", wr_cnt - w0, ram[1]); end
    issue(1'b0, F3_W, 32'h4, 32'h0);
    tick();
    vec_cnt++; if (DONE !== 1'b1 || RDATA !== 32'h1122AA44) begin err_cnt++; $display("FAIL sb_readback done=%b rdata=%h exp 1 1122aa44", DONE, RDATA); end
    tick();
  endtask

  task automatic test_errors();
    logic        wes  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  f3s  [4] = '{F3_H, F3_W, F3_BU, 3'b011};
    logic [31:0] adrs [4] = '{32'h3, 32'h6, 32'h0, 32'h0};
    int r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      issue(wes[i], f3s[i], adrs[i], 32'hFFFFFFFF);
      vec_cnt++; if (DONE !== 1'b1 || ERROR !== 1'b1 || MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin err_cnt++; $display("FAIL err[%0d] done=%b err=%b rd=%b wr=%b exp 1 1 0 0", i, DONE, ERROR, MEM_READ, MEM_WRITE); end
      vec_cnt++; if (RDATA !== 32'h1122AA44) begin err_cnt++; $display("FAIL err_rdata[%0d] got %h exp 1122aa44", i, RDATA); end
      tick();
    end
    vec_cnt++; if (rd_cnt != r0 || wr_cnt != w0) begin err_cnt++; $display("FAIL err_strobes reads=%0d writes=%0d exp 0 0", rd_cnt - r0, wr_cnt - w0); end
  endtask

  task automatic test_back_to_back();
    int w0;
    preload(10'd3, 32'hCAFEF00D);
    preload(10'd4, 32'h55AA55AA);
    w0 = wr_cnt;
    issue(1'b1, F3_H, 32'hE, 32'h00001234);
    REQ = 1'b1; WE = 1'b0; FUNCT3 = F3_W; ADDR = 32'h10;
    vec_cnt++; if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 10'd3) begin err_cnt++; $display("FAIL sh_rd rd=%b addr=%0d exp 1 3", MEM_READ, MEM_ADDRESS); end
    tick();
    vec_cnt++; if (MEM_WRITE !== 1'b1 || MEM_WDATA !== 32'h1234F00D || MEM_ADDRESS !== 10'd3) begin err_cnt++; $display("FAIL sh_wr wr=%b wdata=%h addr=%0d exp 1 1234f00d 3", MEM_WRITE, MEM_WDATA, MEM_ADDRESS); end
    tick();
    vec_cnt++; if (DONE !== 1'b1 || BUSY !== 1'b1) begin err_cnt++; $display("FAIL sh_done done=%b busy=%b exp 1 1", DONE, BUSY); end
    tick();
    vec_cnt++; if (BUSY !== 1'b0 || DONE !== 1'b0 || MEM_READ !== 1'b0) begin err_cnt++; $display("FAIL b2b_idle busy=%b done=%b rd=%b exp 0 0 0", BUSY, DONE, MEM_READ); end
    vec_cnt++; if (wr_cnt - w0 !== 1 || ram[3] !== 32'h1234F00D) begin err_cnt++; $display("FAIL sh_ram writes=%0d ram=%h exp 1 1234f00d", wr_cnt - w0, ram[3]); end
    tick();
    REQ = 1'b0;
    vec_cnt++; if (BUSY !== 1'b1 || MEM_READ !== 1'b1 || MEM_ADDRESS !== 10'd4) begin err_cnt++; $display("FAIL b2b_accept busy=%b rd=%b addr=%0d exp 1 1 4", BUSY, MEM_READ, MEM_ADDRESS); end
    tick();
    vec_cnt++; if (DONE !== 1'b1 || RDATA !== 32'h55AA55AA) begin err_cnt++; $display("FAIL b2b_load done=%b rdata=%h exp 1 55aa55aa", DONE, RDATA); end
    tick();
  endtask

  task automatic test_addr_wrap();
    issue(1'b0, F3_W, 32'h10000008, 32'h0);
    vec_cnt++; if (MEM_ADDRESS !== 10'd2) begin err_cnt++; $display("FAIL wrap_addr got %0d exp 2", MEM_ADDRESS); end
    tick();
    vec_cnt++; if (RDATA !== 32'h80FF7F01) begin err_cnt++; $display("FAIL wrap_rdata got %h exp 80ff7f01", RDATA); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int  w0;
    logic done_seen;
    preload(10'd5, 32'hA5A5A5A5);
    w0 = wr_cnt;
    done_seen = 1'b0;
    issue(1'b1, F3_B, 32'h14, 32'h00000000);
    vec_cnt++; if (MEM_READ !== 1'b1) begin err_cnt++; $display("FAIL rst_rd rd=%b exp 1", MEM_READ); end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    vec_cnt++; if ({BUSY, DONE, ERROR, MEM_READ, MEM_WRITE} !== 5'b0 || MEM_ADDRESS !== '0 || MEM_WDATA !== 32'h0 || RDATA !== 32'h0) begin err_cnt++; $display("FAIL rst_outputs flags=%b addr=%0d wdata=%h rdata=%h exp all 0", {BUSY, DONE, ERROR, MEM_READ, MEM_WRITE}, MEM_ADDRESS, MEM_WDATA, RDATA); end
    for (int i = 0; i < 4; i++) begin
      if (DONE === 1'b1 || BUSY === 1'b1) done_seen = 1'b1;
      tick();
    end
    vec_cnt++; if (done_seen !== 1'b0) begin err_cnt++; $display("FAIL rst_no_done activity=%b exp 0", done_seen); end
    vec_cnt++; if (wr_cnt != w0 || ram[5] !== 32'hA5A5A5A5) begin err_cnt++; $display("FAIL rst_ram writes=%0d ram=%h exp 0 a5a5a5a5", wr_cnt - w0, ram[5]); end
  endtask

  initial begin
    vec_cnt = 0; err_cnt = 0; wr_cnt = 0; rd_cnt = 0;
    RESET = 1'b1; REQ = 1'b0; WE = 1'b0; FUNCT3 = 3'b000; ADDR = '0; WDATA = '0;
    tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
    test_reset();
    preload(10'd2, 32'hDEADBEEF);
    test_lw();
    test_narrow_loads();
    test_sb_rmw();
    test_errors();
    test_back_to_back();
    test_addr_wrap();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store initiator between the single-cycle core's datapath and the word-organised data RAM. It accepts one RV32I load or store request at a time and drives the RAM's WRITE/READ/ADDRESS/DATA_IN pins. Loads return sign- or zero-extended data. Byte and halfword stores are done by read-modify-write of the containing word. It flags misaligned and illegal accesses without touching memory.

## Interface
- AW, 10, RAM word-address width (2^AW words of 32 bits)
- CLK  in  1  single clock, all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- REQ  in  1  access request, sampled only in IDLE
- WE  in  1  1 = store, 0 = load
- FUNCT3  in  3  RV32I size/sign code of the access
- ADDR  in  32  byte address
- WDATA  in  32  store data, right-aligned
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle completion pulse
- ERROR  out  1  valid with DONE: misaligned or illegal FUNCT3
- RDATA  out  32  extended load result, held until the next DONE
- MEM_READ  out  1  to RAM READ
- MEM_WRITE  out  1  to RAM WRITE
- MEM_ADDRESS  out  AW  to RAM ADDRESS, word address
- MEM_WDATA  out  32  to RAM DATA_IN
- MEM_RDATA  in  32  from RAM DATA_OUT; combinational, valid while MEM_READ=1

## Operation
- States: IDLE, RD, WR, RESP, ERR.
- IDLE + REQ=1: latch WE, FUNCT3, ADDR, WDATA. Then decode:
  - Illegal code, or misaligned access: go to ERR.
    - Illegal loads: FUNCT3 011, 110, 111. Illegal stores: any FUNCT3 other than 000, 001, 010.
    - Misaligned: halfword with ADDR[0]=1, or word with ADDR[1:0]≠00.
  - Load, or SB/SH: go to RD.
  - SW: go to WR.
- REQ while BUSY=1 is ignored. No queueing.
- RD:
  - Drive MEM_READ=1 and MEM_ADDRESS=ADDR[AW+1:2]. Capture MEM_RDATA into the word register.
  - Load goes to RESP. SB/SH goes to WR.
- WR:
  - Drive MEM_WRITE=1 and MEM_ADDRESS.
  - MEM_WDATA is WDATA for SW. For SB/SH it is the captured word with the lane selected by ADDR[1:0] (byte) or ADDR[1] (half) replaced by WDATA[7:0] or WDATA[15:0].
  - Go to RESP.
- RESP:
  - DONE=1, ERROR=0. For a load, RDATA is updated with the selected lane.
    - LB/LH: sign-extended. LBU/LHU: zero-extended. LW: unchanged.
  - For a store, RDATA keeps its previous value. Go to IDLE.
- ERR: DONE=1, ERROR=1, RDATA unchanged, no memory strobe. Go to IDLE.
- ADDR bits above AW+1 are ignored, so addresses wrap modulo 2^(AW+2) bytes.
- MEM_READ and MEM_WRITE are never high in the same cycle. Both are 0 outside RD and WR.

## Timing
- Request cycle is N (IDLE, REQ=1). BUSY rises at cycle N+1.
- DONE cycle by access type:
  - Load: N+2 (RD at N+1, RESP at N+2).
  - SW: N+2 (WR at N+1).
  - SB/SH: N+3 (RD, WR, RESP).
  - Error: N+1.
- The earliest accepted next request is in the cycle after DONE, when the block is back in IDLE.
- MEM_* outputs are decoded from the state register and latched request, so they are glitch-free within the cycle. The RAM write commits at the rising edge that ends the WR cycle.
- Reset values: state IDLE, BUSY=0, DONE=0, ERROR=0, RDATA=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WDATA=0.
- Reset mid-operation: at the reset edge the block returns to IDLE and drops any strobe. A store aborted in RD never writes. A store in WR at the reset edge still writes, since the RAM samples on that same edge. No DONE is issued for an aborted request.

## Structure
- Package lsu_pkg:
  - FUNCT3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State enum lsu_state_t.
- Sub-module lsu_align, purely combinational, two functions:
  - Lane extract and extend for loads: FUNCT3, ADDR[1:0], word → RDATA value.
  - Lane merge for stores: FUNCT3, ADDR[1:0], old word, WDATA → new word.
- Top module holds the FSM, the request latch and the word register.

## Test plan
- Reset, then LW at ADDR 0x8 with RAM[2]=0xDEADBEEF → MEM_READ=1 at N+1 with MEM_ADDRESS=2; DONE at N+2 with RDATA=0xDEADBEEF and ERROR=0.
- LB at ADDR 0xB and LBU at ADDR 0xB, RAM[2]=0x80FF7F01 → RDATA=0xFFFFFF80 and 0x00000080 respectively.
- SB 0xAA at ADDR 0x5, RAM[1]=0x11223344 → RD at N+1, WR at N+2 with MEM_WDATA=0x1122AA44, DONE at N+3; a following LW at 0x4 returns 0x1122AA44.
- LH at ADDR 0x3 and SW at ADDR 0x6 → DONE with ERROR=1 at N+1; MEM_READ and MEM_WRITE stay 0 throughout.
- REQ held high during a busy SH → exactly one access performed; a new request is accepted only in the cycle after DONE.
- RESET asserted during the RD cycle of an SB → next cycle IDLE with all outputs 0; RAM contents unchanged; no DONE pulse.
